regfile_writeback: RTL and testbench

Write-side driver for the processor's 32-entry register file. It accepts completed results from the ALU and the load unit over valid/ready handshakes, round-robin arbitrates them onto the register file's single write port (`rd`, `write_data`, `w_en`), and keeps a per-register pending-write scoreboard. Decode uses the scoreboard's `busy` vector for read-after-write hazard stalls. The block sits between execute/memory and the register file.

---
 rtl/rv_pkg.sv | 19 +
 rtl/wb_scoreboard.sv | 70 +++++++
 rtl/regfile_writeback.sv | 98 +++++++++
 tb/tb_regfile_writeback.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared writeback definitions: register file geometry and result-source encoding.
`default_nettype none

package rv_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 1 << REG_AW;

  localparam logic [1:0] CNT_MAX = 2'd3;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LD  = 1'b1
  } wb_src_t;

endpackage

`default_nettype wire

// File: rtl/wb_scoreboard.sv
// Per-register pending-write scoreboard: 2-bit saturating counters, busy vector,
// issue back-pressure and a sticky underflow flag.
`default_nettype none

module wb_scoreboard #(
  parameter int REG_AW = rv_pkg::REG_AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inc_en,
  input  logic [REG_AW-1:0]        inc_idx,
  input  logic                     dec_en,
  input  logic [REG_AW-1:0]        dec_idx,
  input  logic [REG_AW-1:0]        query_idx,
  output logic                     query_ready,
  output logic [(1<<REG_AW)-1:0]   busy,
  output logic                     err
);

  import rv_pkg::*;

  localparam int N_REGS = 1 << REG_AW;

  logic [N_REGS-1:0][1:0] cnt;
  logic                   underflow;

  for (genvar i = 0; i < N_REGS; i++) begin : g_cnt
    if (i == 0) begin : g_zero
      assign cnt[i] = 2'd0;
    end else begin : g_reg
      logic [1:0] q;
      logic       inc_hit;
      logic       dec_hit;

      assign inc_hit = inc_en & (inc_idx == REG_AW'(i));
      assign dec_hit = dec_en & (dec_idx == REG_AW'(i));

      // A same-cycle issue and retire cancel; otherwise saturate at both ends.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= 2'd0;
        end else begin
          case ({inc_hit, dec_hit})
            2'b10:   if (q != CNT_MAX) q <= q + 2'd1;
            2'b01:   if (q != 2'd0)    q <= q - 2'd1;
            default: q <= q;
          endcase
        end
      end

      assign cnt[i] = q;
    end

    assign busy[i] = (cnt[i] != 2'd0);
  end

  assign query_ready = (cnt[query_idx] != CNT_MAX);
  assign underflow   = dec_en & (cnt[dec_idx] == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (underflow) begin
      err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_writeback.sv
// Register file write-side driver: round-robin arbitration of ALU and load results
// onto the single write port, plus the pending-write scoreboard.
`default_nettype none

module regfile_writeback #(
  parameter int XLEN   = rv_pkg::XLEN,
  parameter int REG_AW = rv_pkg::REG_AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic [REG_AW-1:0]        issue_rd,
  output logic                     issue_ready,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [REG_AW-1:0]        alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [REG_AW-1:0]        ld_rd,
  input  logic [XLEN-1:0]          ld_data,
  output logic [REG_AW-1:0]        rd,
  output logic [XLEN-1:0]          write_data,
  output logic                     w_en,
  output logic [(1<<REG_AW)-1:0]   busy,
  output logic                     err
);

  import rv_pkg::*;

  wb_src_t           last_tie;
  logic              tie;
  logic              grant_alu;
  logic              grant_ld;
  logic              accept;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;
  logic              issue_fire;

  // On a tie the source that lost the previous tie wins this one.
  always_comb begin
    tie       = alu_valid & ld_valid;
    grant_alu = 1'b0;
    grant_ld  = 1'b0;
    if (tie) begin
      if (last_tie == WB_SRC_ALU) grant_ld  = 1'b1;
      else                        grant_alu = 1'b1;
    end else begin
      grant_alu = alu_valid;
      grant_ld  = ld_valid;
    end
    sel_rd   = grant_ld ? ld_rd   : alu_rd;
    sel_data = grant_ld ? ld_data : alu_data;
  end

  assign alu_ready  = alu_valid & grant_alu;
  assign ld_ready   = ld_valid & grant_ld;
  assign accept     = alu_ready | ld_ready;
  assign issue_fire = issue_valid & issue_ready & (issue_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd         <= '0;
      write_data <= '0;
      w_en       <= 1'b0;
      last_tie   <= WB_SRC_ALU;
    end else begin
      w_en <= 1'b0;
      // Writes to x0 are consumed but never reach the register file.
      if (accept && (sel_rd != '0)) begin
        w_en       <= 1'b1;
        rd         <= sel_rd;
        write_data <= sel_data;
      end
      if (tie) begin
        last_tie <= grant_ld ? WB_SRC_LD : WB_SRC_ALU;
      end
    end
  end

  wb_scoreboard #(
    .REG_AW (REG_AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_en      (issue_fire),
    .inc_idx     (issue_rd),
    .dec_en      (w_en),
    .dec_idx     (rd),
    .query_idx   (issue_rd),
    .query_ready (issue_ready),
    .busy        (busy),
    .err         (err)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus randomized traffic
// against a cycle-level model of pending counts, arbitration fairness and write port.
`default_nettype none

module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic        w_en;
  logic [31:0] busy;
  logic        err;

  int tests = 0;
  int fails = 0;

  int          mcnt [32];
  bit          m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_err;
  bit          m_last_ld;

  bit ga, gl;
  int ord [4] = '{2, 1, 2, 1};

  always #5 clk = ~clk;

  regfile_writeback dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .rd          (rd),
    .write_data  (write_data),
    .w_en        (w_en),
    .busy        (busy),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    for (int i = 0; i < 32; i++) b[i] = (mcnt[i] != 0);
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    m_wen = 0; m_rd = '0; m_data = '0; m_err = 0; m_last_ld = 0;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = '0;
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    ld_valid = 0; ld_rd = '0; ld_data = '0;
  endtask

  // Called at posedge+1 with inputs applied; checks readies, crosses one edge,
  // then checks the registered outputs against the model.
  task automatic cycle(output bit acc_alu, output bit acc_ld);
    bit irdy, ifire, win_ld, win_alu;
    logic [4:0] dest;
    #1;
    irdy = (issue_rd == 0) || (mcnt[issue_rd] != 3);
    if (alu_valid && ld_valid) win_ld = !m_last_ld;
    else                       win_ld = ld_valid;
    win_alu = alu_valid && !win_ld;
    chk("issue_ready", 32'(issue_ready), 32'(irdy));
    chk("alu_ready", 32'(alu_ready), 32'(win_alu));
    chk("ld_ready", 32'(ld_ready), 32'(win_ld));
    @(posedge clk);
    ifire = issue_valid && irdy && (issue_rd != 0);
    if (m_wen && mcnt[m_rd] == 0) m_err = 1;
    if (!(m_wen && ifire && issue_rd == m_rd)) begin
      if (ifire) mcnt[issue_rd]++;
      if (m_wen && mcnt[m_rd] > 0) mcnt[m_rd]--;
    end
    dest = win_ld ? ld_rd : alu_rd;
    if ((win_alu || win_ld) && dest != 0) begin
      m_wen = 1; m_rd = dest; m_data = win_ld ? ld_data : alu_data;
    end else begin
      m_wen = 0;
    end
    if (alu_valid && ld_valid) m_last_ld = win_ld;
    acc_alu = win_alu;
    acc_ld  = win_ld;
    #1;
    chk("w_en", 32'(w_en), 32'(m_wen));
    chk("rd", 32'(rd), 32'(m_rd));
    chk("write_data", write_data, m_data);
    chk("busy", busy, model_busy());
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    idle();
    model_reset();
    #1;
    chk("rst_async_wen", 32'(w_en), 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_err", 32'(err), 0);
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wen", 32'(w_en), 0);
    chk("reset_rd", 32'(rd), 0);
    chk("reset_wdata", write_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err", 32'(err), 0);
    rst_n = 1;

    // Single ALU write to x5
    issue_valid = 1; issue_rd = 5;
    cycle(ga, gl);
    chk("iss5_busy", 32'(busy[5]), 1);
    issue_valid = 0;
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    cycle(ga, gl);
    chk("alu5_wen", 32'(w_en), 1);
    chk("alu5_rd", 32'(rd), 5);
    chk("alu5_data", write_data, 32'hDEADBEEF);
    chk("alu5_busy_n1", 32'(busy[5]), 1);
    alu_valid = 0;
    cycle(ga, gl);
    chk("alu5_wen_drop", 32'(w_en), 0);
    chk("alu5_busy_n2", 32'(busy[5]), 0);

    // Reset while a write and a pending count are in flight
    issue_valid = 1; issue_rd = 5;
    cycle(ga, gl);
    issue_valid = 0;
    alu_valid = 1; alu_rd = 5; alu_data = 32'h12345678;
    cycle(ga, gl);
    chk("midop_wen", 32'(w_en), 1);
    chk("midop_busy5", 32'(busy[5]), 1);
    do_reset();

    // Tie arbitration: x1 (ALU) vs x2 (load)
    for (int k = 0; k < 4; k++) begin
      issue_valid = 1; issue_rd = (k % 2 == 0) ? 5'd1 : 5'd2;
      cycle(ga, gl);
    end
    issue_valid = 0;
    alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
    ld_valid  = 1; ld_rd  = 2; ld_data  = 32'h22;
    for (int k = 0; k < 4; k++) begin
      cycle(ga, gl);
      chk("tie_wen", 32'(w_en), 1);
      chk("tie_rd", 32'(rd), 32'(ord[k]));
      chk("tie_data", write_data, (ord[k] == 2) ? 32'h22 : 32'h11);
    end
    idle();
    cycle(ga, gl);
    chk("tie_busy_drain", busy, 0);
    chk("tie_err", 32'(err), 0);

    // Register 0
    issue_valid = 1; issue_rd = 0;
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF;
    #1;
    chk("x0_alu_ready", 32'(alu_ready), 1);
    cycle(ga, gl);
    chk("x0_wen", 32'(w_en), 0);
    chk("x0_busy0", 32'(busy[0]), 0);
    chk("x0_err", 32'(err), 0);
    idle();
    cycle(ga, gl);
    chk("x0_wen_after", 32'(w_en), 0);

    // Counter saturation on x7
    issue_valid = 1; issue_rd = 7;
    repeat (3) cycle(ga, gl);
    #1;
    chk("sat_issue_ready", 32'(issue_ready), 0);
    cycle(ga, gl);
    issue_valid = 0;
    alu_valid = 1; alu_rd = 7;
    for (int k = 0; k < 3; k++) begin
      alu_data = $urandom;
      cycle(ga, gl);
    end
    alu_valid = 0;
    cycle(ga, gl);
    chk("sat_busy7", 32'(busy[7]), 0);
    chk("sat_err", 32'(err), 0);

    // Spurious load write to x9
    ld_valid = 1; ld_rd = 9; ld_data = $urandom;
    cycle(ga, gl);
    chk("spur_wen", 32'(w_en), 1);
    chk("spur_rd", 32'(rd), 9);
    ld_valid = 0;
    cycle(ga, gl);
    chk("spur_err", 32'(err), 1);
    repeat (3) cycle(ga, gl);
    chk("spur_err_sticky", 32'(err), 1);
    do_reset();

    // Randomized traffic
    ga = 1; gl = 1;
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        do_reset();
        ga = 1; gl = 1;
      end
      issue_valid = 1'($urandom % 2);
      issue_rd    = 5'($urandom % 8);
      if (!alu_valid || ga) begin
        alu_valid = ($urandom % 3) != 0;
        alu_rd    = 5'($urandom % 8);
        alu_data  = $urandom;
      end
      if (!ld_valid || gl) begin
        ld_valid = ($urandom % 3) != 0;
        ld_rd    = 5'($urandom % 8);
        ld_data  = $urandom;
      end
      cycle(ga, gl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
